// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST block.
// Holds the FSM state enumeration, vector/counter widths and the reference
// sum used to judge the adder under test.
package adder_bist_pkg;

    localparam int unsigned VEC_COUNT = 512;
    localparam int unsigned IDX_W     = 9;
    localparam int unsigned ERR_W     = 10;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    // Golden 5-bit result {carry, sum} of a 4-bit add with carry-in.
    function automatic logic [4:0] ref_sum(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic       cin);
        return {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    endfunction

endpackage

// File: rtl/bist_vector_gen.sv
// Vector generator for the adder BIST.
// Holds the 9-bit vector index and the settle counter, and drives the
// operands of the adder under test (zero when not enabled).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         restart at vector 0 with the settle counter cleared
//   drive         FSM is holding the current vector for settling
//   step          advance to the next vector
//   enable        operands are presented (otherwise forced to 0)
//   a, b, cin     operands for the adder under test
//   idx           current vector index
//   settled       last settle cycle of the current vector
//   last          current vector is the final one
module bist_vector_gen
    import adder_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             drive,
    input  logic             step,
    input  logic             enable,
    output logic [3:0]       a,
    output logic [3:0]       b,
    output logic             cin,
    output logic [IDX_W-1:0] idx,
    output logic             settled,
    output logic             last
);

    logic [IDX_W-1:0] idx_q;
    logic [3:0]       cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            if (clear) begin
                idx_q <= '0;
            end else if (step && !last) begin
                // Index stops at the final vector; it never wraps.
                idx_q <= idx_q + 1'b1;
            end

            if (clear) begin
                cnt_q <= '0;
            end else if (drive) begin
                cnt_q <= settled ? 4'd0 : cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        settled = drive && (cnt_q == 4'(SETTLE_CYCLES - 1));
        last    = (idx_q == IDX_W'(VEC_COUNT - 1));
        idx     = idx_q;
        // Index layout: A outer, B middle, carry-in innermost.
        a       = enable ? idx_q[8:5] : 4'd0;
        b       = enable ? idx_q[4:1] : 4'd0;
        cin     = enable ? idx_q[0]   : 1'b0;
    end

endmodule

// File: rtl/adder_bist.sv
// Built-in self test for an external 4-bit adder.
// Sweeps all 512 operand/carry combinations, holds each for SETTLE_CYCLES
// cycles, then compares the adder response with the reference sum and
// records the error count and the first failing vector.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                run request (accepted only when idle or done)
//   a_out, b_out, cin_out operands to the adder under test
//   s_in, c_in           sum and carry-out from the adder under test
//   busy, done, pass     run status; pass valid while done
//   err_count            mismatching vectors in the current/last run
//   fail_vec, fail_valid first mismatching vector index and its valid flag
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [3:0]       a_out,
    output logic [3:0]       b_out,
    output logic             cin_out,
    input  logic [3:0]       s_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] fail_vec,
    output logic             fail_valid
);

    state_e           state_q, state_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [IDX_W-1:0] fvec_q, fvec_d;
    logic             fvalid_q, fvalid_d;

    logic             clear, step, drive, enable;
    logic [IDX_W-1:0] idx;
    logic             settled, last, mismatch;

    bist_vector_gen #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_vector_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .drive   (drive),
        .step    (step),
        .enable  (enable),
        .a       (a_out),
        .b       (b_out),
        .cin     (cin_out),
        .idx     (idx),
        .settled (settled),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign mismatch = ({c_in, s_in} != ref_sum(a_out, b_out, cin_out));

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;
        clear    = 1'b0;
        step     = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StDrive;
                    clear    = 1'b1;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                end
            end
            StDrive: begin
                if (settled) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (mismatch) begin
                    // At most 512 mismatches per run, so 10 bits never overflow.
                    err_d = err_q + ERR_W'(1);
                    if (!fvalid_q) begin
                        fvec_d   = idx;
                        fvalid_d = 1'b1;
                    end
                end
                if (last) begin
                    state_d = StDone;
                end else begin
                    step    = 1'b1;
                    state_d = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        drive      = (state_q == StDrive);
        enable     = (state_q == StDrive) || (state_q == StSample);
        busy       = enable;
        done       = (state_q == StDone);
        pass       = done && (err_q == '0);
        err_count  = err_q;
        fail_vec   = fvec_q;
        fail_valid = fvalid_q;
    end

endmodule
